hilo_muldiv_ctrl: RTL and testbench

- Owns the HI/LO register pair for mips_cpu_harvard.
- Sequences MULT/MULTU/DIV/DIVU as 32-iteration shift-add and restoring-division operations.
- Services MTHI/MTLO/MFHI/MFLO, and stalls the decode stage whenever an HI/LO access collides with an operation in flight.
- Sits beside the ALU in the execute stage; its single requester is the CPU control unit.

---
 rtl/hilo_muldiv_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Owns the architectural HI/LO pair. Runs MULT/MULTU as a 32-step
//   shift-add and DIV/DIVU as a 32-step restoring division, services
//   MTHI/MTLO/MFHI/MFLO, and stalls any request that arrives while an
//   operation is in flight.
// Ports:
//   clk          system clock (rising edge)
//   reset        asynchronous active-low reset
//   op_valid     request present this cycle
//   op           0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
//   rs_data      multiplicand / dividend / MTHI-MTLO source
//   rt_data      multiplier / divisor
//   stall        request cannot be accepted this cycle
//   busy         multiply/divide in flight
//   result       MFHI/MFLO read data (0 when not valid)
//   result_valid result carries accepted MFHI/MFLO data
//   hi, lo       architectural HI and LO
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam int unsigned     CW   = $clog2(ITER);
    localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic [CW-1:0]        counter;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    // MUL: {partial product high, multiplier shifting out / product low}
    // DIV: {remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0]   acc;
    logic                 neg_main;   // negate product or quotient
    logic                 neg_rem;    // negate remainder
    logic                 div_mode;

    logic                 accept;
    logic                 signed_op;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed;
    logic [WIDTH-1:0]     rem_fixed;

    assign busy   = (state != IDLE);
    assign stall  = op_valid & busy;
    assign accept = op_valid & ~stall;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        rs_mag    = (signed_op && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_mag    = (signed_op && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    end

    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // Bit WIDTH of the difference is set exactly when the trial subtract underflows.
        div_diff   = div_shift - {1'b0, b_reg};
        prod_fixed = neg_main ? -acc : acc;
        quo_fixed  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fixed  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        result_valid = reset & accept & ((op == OP_MFHI) || (op == OP_MFLO));
        result       = '0;
        if (result_valid) begin
            result = (op == OP_MFHI) ? hi : lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_mode <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_reg    <= rs_mag;
                                b_reg    <= rt_mag;
                                acc      <= {{WIDTH{1'b0}}, rt_mag};
                                neg_main <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                neg_rem  <= 1'b0;
                                div_mode <= 1'b0;
                                counter  <= '0;
                                state    <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_reg    <= rs_mag;
                                b_reg    <= rt_mag;
                                acc      <= {{WIDTH{1'b0}}, rs_mag};
                                neg_main <= signed_op & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                neg_rem  <= signed_op & rs_data[WIDTH-1];
                                div_mode <= 1'b1;
                                counter  <= '0;
                                state    <= DIV;
                            end
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc     <= {mul_sum, acc[WIDTH-1:1]};
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state <= FIX;
                    end
                end
                DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_mode) begin
                        // With a zero divisor every trial subtract succeeds, so the
                        // remainder ends as |rs| and sign-restores to rs itself.
                        hi <= rem_fixed;
                        lo <= (b_reg == '0) ? '1 : quo_fixed;
                    end else begin
                        {hi, lo} <= prod_fixed;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op           (op),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules.
    function automatic void ref_muldiv(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] h, output logic [31:0] l);
        longint      p;
        logic [63:0] u;
        int          sa;
        int          sb;
        h = '0;
        l = '0;
        case (o)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = p;
            end
            OP_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                {h, l} = u;
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 32'd0;
                    l = 32'h8000_0000;
                end else begin
                    sa = a;
                    sb = b;
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    task automatic run_muldiv(input string name, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cnt;
        @(negedge clk);
        op = o;
        rs_data = a;
        rt_data = b;
        op_valid = 1'b1;
        #1 check({name, " stall_at_accept"}, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 op_valid = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, cnt, 32'd33);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        op = o;
        rs_data = v;
        op_valid = 1'b1;
        #1 check("mt stall", {31'd0, stall}, 32'd0);
        check("mt result_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1 op_valid = 1'b0;
        if (o == OP_MTHI) m_hi = v;
        else m_lo = v;
        check("mt hi", hi, m_hi);
        check("mt lo", lo, m_lo);
    endtask

    task automatic do_mf(input logic [2:0] o);
        @(negedge clk);
        op = o;
        op_valid = 1'b1;
        #1 check("mf result_valid", {31'd0, result_valid}, 32'd1);
        check("mf result", result, (o == OP_MFHI) ? m_hi : m_lo);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          cnt;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eh;
        logic [31:0] el;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        // Reset state, with a read request present while reset is held.
        #3 reset = 1'b0;
        op = OP_MFHI;
        op_valid = 1'b1;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset result_valid", {31'd0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_muldiv($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                       vecs[i].eh, vecs[i].el);
        end

        // MFLO held from the cycle after a MULT accept overlaps all 33 busy cycles.
        @(negedge clk);
        op = OP_MULT;
        rs_data = 32'd6;
        rt_data = 32'd7;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op = OP_MFLO;
        cnt = 0;
        while (stall === 1'b1 && cnt < 100) begin
            if (result_valid !== 1'b0) check("stalled result_valid", {31'd0, result_valid}, 32'd0);
            cnt++;
            @(posedge clk);
            #1;
        end
        check("mflo stall_cycles", cnt, 32'd33);
        check("mflo result", result, 32'd42);
        check("mflo result_valid", {31'd0, result_valid}, 32'd1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd42;

        // Move-to followed by move-from on the very next cycle.
        do_mt(OP_MTHI, 32'd8);
        do_mf(OP_MFHI);
        do_mt(OP_MTLO, 32'h1234);
        do_mf(OP_MFLO);
        check("hi kept after mtlo", hi, 32'd8);

        // Asynchronous reset during a divide.
        @(negedge clk);
        op = OP_DIVU;
        rs_data = 32'd100;
        rt_data = 32'd7;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 check("busy before abort", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        run_muldiv("divu after reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Randomized mix of all op classes against the reference model.
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (ro <= OP_DIVU) begin
                ref_muldiv(ro, ra, rb, eh, el);
                run_muldiv($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, eh, el);
            end else if (ro == OP_MTHI || ro == OP_MTLO) begin
                do_mt(ro, ra);
            end else begin
                do_mf(ro);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
